// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler
//   Pixel-clock raster and period scheduler for an HDMI/TMDS transmitter.
//   Walks the raster (cx, cy) and, for every pixel, reports which TMDS period
//   the encoder should emit: control, video, video guard band, data island or
//   data-island guard band. It also produces the CTL3..CTL0 preamble codes,
//   {vsync, hsync}, and the packet bit index / ack used to pace a
//   32-cycle-per-packet source. All outputs are registered together, so a
//   given cycle's outputs always describe the same pixel.
//
// Ports
//   clk_pixel    in   pixel clock, the only clock
//   reset_n      in   asynchronous active-low reset
//   packet_valid in   source has a 32-cycle packet ready (held until ack)
//   packet_ack   out  one-cycle pulse on the last cycle of each packet
//   packet_bit   out  cycle index 0..31 within the current packet
//   mode         out  0 control, 1 video, 2 video guard, 3 island, 4 island guard
//   ctl          out  CTL3..CTL0 for the channel 1/2 control codes
//   sync         out  {vsync, hsync}, active high
//   cx, cy       out  raster position of the pixel described by the outputs
//
// Island FSM
//   state    | meaning
//   IDLE     | no island; raster timing and video preamble only
//   DI_PRE   | 8-cycle data-island preamble, ctl = 0101
//   DI_LEAD  | 2-cycle leading island guard band
//   DI_PKT   | packet payload, packet_bit 0..31
//   DI_TRAIL | 2-cycle trailing island guard band

module hdmi_period_scheduler #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FRONT      = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BACK       = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33,
   parameter int ISLAND_START = 4,
   parameter int MAX_PACKETS  = 2
) (
   input  logic        clk_pixel,
   input  logic        reset_n,
   input  logic        packet_valid,
   output logic        packet_ack,
   output logic [4:0]  packet_bit,
   output logic [2:0]  mode,
   output logic [3:0]  ctl,
   output logic [1:0]  sync,
   output logic [15:0] cx,
   output logic [15:0] cy
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [15:0] HT_LAST  = 16'(H_TOTAL - 1);
   localparam logic [15:0] VT_LAST  = 16'(V_TOTAL - 1);
   localparam logic [15:0] HA       = 16'(H_ACTIVE);
   localparam logic [15:0] VA       = 16'(V_ACTIVE);
   localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FRONT);
   localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FRONT);
   localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [15:0] ISL_X    = 16'(H_ACTIVE + ISLAND_START);
   localparam logic [15:0] PRE_X    = 16'(H_TOTAL - 10);
   localparam logic [15:0] GUARD_X  = 16'(H_TOTAL - 2);
   localparam logic [4:0]  PKT_MAX  = 5'(MAX_PACKETS);

   // The whole island (preamble, guards, packets) must finish before the
   // video preamble of the next line begins.
   if (MAX_PACKETS < 1 || MAX_PACKETS > 18 ||
       H_ACTIVE + ISLAND_START + 12 + 32 * MAX_PACKETS > H_TOTAL - 10) begin : g_param_check
      $error("hdmi_period_scheduler: data island does not fit in horizontal blanking");
   end

   typedef enum logic [2:0] {IDLE, DI_PRE, DI_LEAD, DI_PKT, DI_TRAIL} island_state_t;

   island_state_t state, state_n;
   logic [2:0]    tmr, tmr_n;
   logic [4:0]    pkt_cnt, pkt_cnt_n;
   logic [4:0]    bit_n;
   logic          running;
   logic [15:0]   nx, ny;
   logic          next_line_active;
   logic [2:0]    mode_n;
   logic [3:0]    ctl_n;
   logic [1:0]    sync_n;
   logic          ack_n;

   // Everything below describes the pixel that will be presented after the
   // next edge. The first edge after reset presents (0,0) rather than
   // advancing, so the raster restarts cleanly at the origin.
   always_comb begin
      nx = cx + 16'd1;
      ny = cy;
      if (!running) begin
         nx = 16'd0;
         ny = 16'd0;
      end else if (cx == HT_LAST) begin
         nx = 16'd0;
         ny = (cy == VT_LAST) ? 16'd0 : cy + 16'd1;
      end

      state_n   = state;
      tmr_n     = tmr;
      pkt_cnt_n = pkt_cnt;
      bit_n     = 5'd0;
      case (state)
         IDLE: begin
            if (nx == ISL_X && packet_valid) begin
               state_n = DI_PRE;
               tmr_n   = 3'd7;
            end
         end
         DI_PRE: begin
            if (tmr == 3'd0) begin
               state_n = DI_LEAD;
               tmr_n   = 3'd1;
            end else begin
               tmr_n = tmr - 3'd1;
            end
         end
         DI_LEAD: begin
            if (tmr == 3'd0) begin
               state_n   = DI_PKT;
               pkt_cnt_n = 5'd1;
            end else begin
               tmr_n = tmr - 3'd1;
            end
         end
         DI_PKT: begin
            if (packet_bit == 5'd31) begin
               if (packet_valid && pkt_cnt < PKT_MAX) begin
                  pkt_cnt_n = pkt_cnt + 5'd1;
               end else begin
                  state_n = DI_TRAIL;
                  tmr_n   = 3'd1;
               end
            end else begin
               bit_n = packet_bit + 5'd1;
            end
         end
         DI_TRAIL: begin
            if (tmr == 3'd0) begin
               state_n = IDLE;
            end else begin
               tmr_n = tmr - 3'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Line following ny; the last line wraps to line 0, which is active.
      next_line_active = (ny == VT_LAST) ? 1'b1 : ((ny + 16'd1) < VA);

      mode_n = 3'd0;
      ctl_n  = 4'd0;
      case (state_n)
         DI_PKT:           mode_n = 3'd3;
         DI_LEAD, DI_TRAIL: mode_n = 3'd4;
         DI_PRE:           ctl_n  = 4'b0101;
         default: begin
            if (nx < HA && ny < VA) begin
               mode_n = 3'd1;
            end else if (next_line_active && nx >= GUARD_X) begin
               mode_n = 3'd2;
            end else if (next_line_active && nx >= PRE_X) begin
               ctl_n = 4'b0001;
            end
         end
      endcase

      sync_n = {(ny >= VS_START && ny < VS_END), (nx >= HS_START && nx < HS_END)};
      ack_n  = (state_n == DI_PKT) && (bit_n == 5'd31);
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         running    <= 1'b0;
         state      <= IDLE;
         tmr        <= 3'd0;
         pkt_cnt    <= 5'd0;
         cx         <= 16'd0;
         cy         <= 16'd0;
         mode       <= 3'd0;
         ctl        <= 4'd0;
         sync       <= 2'd0;
         packet_bit <= 5'd0;
         packet_ack <= 1'b0;
      end else begin
         running    <= 1'b1;
         state      <= state_n;
         tmr        <= tmr_n;
         pkt_cnt    <= pkt_cnt_n;
         cx         <= nx;
         cy         <= ny;
         mode       <= mode_n;
         ctl        <= ctl_n;
         sync       <= sync_n;
         packet_bit <= bit_n;
         packet_ack <= ack_n;
      end
   end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Testbench for hdmi_period_scheduler.
//   dut   : default 640x480 timing, island/preamble/reset scenarios, checked by
//           a position-keyed pixel scoreboard and an ack scoreboard.
//   dut_s : reduced timing (102x12) so a whole frame can be swept cheaply.

module tb_hdmi_period_scheduler;

   logic        clk_pixel = 1'b0;
   logic        reset_n = 1'b0;
   logic        packet_valid = 1'b0;
   logic        packet_ack;
   logic [4:0]  packet_bit;
   logic [2:0]  mode;
   logic [3:0]  ctl;
   logic [1:0]  sync;
   logic [15:0] cx, cy;

   logic        s_reset_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ack;
   logic [4:0]  s_bit;
   logic [2:0]  s_mode;
   logic [3:0]  s_ctl;
   logic [1:0]  s_sync;
   logic [15:0] s_cx, s_cy;

   always #5 clk_pixel = ~clk_pixel;

   hdmi_period_scheduler dut (
      .clk_pixel    (clk_pixel),
      .reset_n      (reset_n),
      .packet_valid (packet_valid),
      .packet_ack   (packet_ack),
      .packet_bit   (packet_bit),
      .mode         (mode),
      .ctl          (ctl),
      .sync         (sync),
      .cx           (cx),
      .cy           (cy)
   );

   hdmi_period_scheduler #(
      .H_ACTIVE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(50),
      .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(1), .V_BACK(3),
      .ISLAND_START(4), .MAX_PACKETS(1)
   ) dut_s (
      .clk_pixel    (clk_pixel),
      .reset_n      (s_reset_n),
      .packet_valid (s_valid),
      .packet_ack   (s_ack),
      .packet_bit   (s_bit),
      .mode         (s_mode),
      .ctl          (s_ctl),
      .sync         (s_sync),
      .cx           (s_cx),
      .cy           (s_cy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         y;
      int         x;
      logic [2:0] mode;
      logic [3:0] ctl;
      logic [1:0] sync;
      logic [4:0] pbit;
      logic       ack;
   } px_exp_t;

   typedef struct {
      int y;
      int x;
   } pos_t;

   px_exp_t px_q[$];
   pos_t    ack_q[$];

   int bx = 0, by = 0;
   bit run = 0;

   function automatic logic [1:0] main_sync(input int y, input int x);
      return {(y >= 490 && y < 492), (x >= 656 && x < 752)};
   endfunction

   task automatic push_px(input int y, input int x, input logic [2:0] m,
                          input logic [3:0] c, input logic [4:0] b, input logic a);
      px_exp_t e;
      e.y = y; e.x = x; e.mode = m; e.ctl = c; e.pbit = b; e.ack = a;
      e.sync = main_sync(y, x);
      px_q.push_back(e);
   endtask

   task automatic push_ack(input int y, input int x);
      pos_t p;
      p.y = y; p.x = x;
      ack_q.push_back(p);
   endtask

   task automatic check_vec(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic wait_pos(input int y, input int x, input int budget);
      bit found = 0;
      for (int n = 0; n < budget && !found; n++) begin
         @(posedge clk_pixel); #1;
         if (cy == 16'(y) && cx == 16'(x)) found = 1;
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout waiting for cy=%0d cx=%0d: at cy=%0d cx=%0d", y, x, cy, cx);
      end
   endtask

   // Monitor: tracks the pixel position independently of the DUT and pops
   // scoreboard entries when their pixel comes up.
   initial begin
      px_exp_t e;
      pos_t    p;
      forever begin
         @(posedge clk_pixel); #1;
         if (!reset_n) begin
            run = 0;
         end else begin
            if (!run) begin
               run = 1; bx = 0; by = 0;
            end else if (bx == 799) begin
               bx = 0;
               by = (by == 524) ? 0 : by + 1;
            end else begin
               bx++;
            end
            if (px_q.size() > 0 && px_q[0].y == by && px_q[0].x == bx) begin
               e = px_q.pop_front();
               n_checks++;
               if ({cx, cy, mode, ctl, sync, packet_bit, packet_ack} !==
                   {16'(e.x), 16'(e.y), e.mode, e.ctl, e.sync, e.pbit, e.ack}) begin
                  n_fail++;
                  $display("FAIL pixel y=%0d x=%0d: got cx=%0d cy=%0d mode=%0d ctl=%b sync=%b bit=%0d ack=%b, want mode=%0d ctl=%b sync=%b bit=%0d ack=%b",
                           e.y, e.x, cx, cy, mode, ctl, sync, packet_bit, packet_ack,
                           e.mode, e.ctl, e.sync, e.pbit, e.ack);
               end
            end
            if (packet_ack) begin
               n_checks++;
               if (ack_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL ack: unexpected ack at y=%0d x=%0d, want none", by, bx);
               end else begin
                  p = ack_q.pop_front();
                  if (p.y != by || p.x != bx) begin
                     n_fail++;
                     $display("FAIL ack: got ack at y=%0d x=%0d, want y=%0d x=%0d", by, bx, p.y, p.x);
                  end
               end
            end
         end
      end
   end

   initial begin
      int pos_err, mode_err, ctl_err, sync_err, mode1_cnt, hs_cnt, vs_cnt;
      bit na;
      logic [2:0] em;
      logic [3:0] ec;
      logic [1:0] es;
      pos_err = 0; mode_err = 0; ctl_err = 0; sync_err = 0;
      mode1_cnt = 0; hs_cnt = 0; vs_cnt = 0;

      repeat (3) @(posedge clk_pixel);
      #1;
      check_vec("reset_hold", 64'({cx, cy, mode, ctl, sync, packet_bit, packet_ack}), 64'd0);

      // Full frame sweep on the reduced-timing instance.
      @(negedge clk_pixel);
      s_reset_n = 1'b1;
      for (int y = 0; y < 12; y++) begin
         for (int x = 0; x < 102; x++) begin
            @(posedge clk_pixel); #1;
            na = (y == 11) ? 1'b1 : (y + 1 < 6);
            em = (x < 40 && y < 6) ? 3'd1 : ((na && x >= 100) ? 3'd2 : 3'd0);
            ec = (na && x >= 92 && x < 100) ? 4'd1 : 4'd0;
            es = {(y == 8), (x >= 44 && x < 52)};
            if (s_cx != 16'(x) || s_cy != 16'(y)) pos_err++;
            if (s_mode != em) mode_err++;
            if (s_ctl != ec) ctl_err++;
            if (s_sync != es) sync_err++;
            if (s_mode == 3'd1) mode1_cnt++;
            if (s_sync[0]) hs_cnt++;
            if (s_sync[1]) vs_cnt++;
         end
      end
      check_vec("frame_pos_err", 64'(pos_err), 64'd0);
      check_vec("frame_mode_err", 64'(mode_err), 64'd0);
      check_vec("frame_ctl_err", 64'(ctl_err), 64'd0);
      check_vec("frame_sync_err", 64'(sync_err), 64'd0);
      check_vec("frame_mode1_count", 64'(mode1_cnt), 64'd240);
      check_vec("frame_hsync_count", 64'(hs_cnt), 64'd96);
      check_vec("frame_vsync_count", 64'(vs_cnt), 64'd102);
      @(posedge clk_pixel); #1;
      check_vec("frame_wrap", 64'({s_cx, s_cy, s_mode}), 64'({16'd0, 16'd0, 3'd1}));

      // Line 0: first pixel after reset, hsync edges, video preamble/guard.
      push_px(0, 0,   3'd1, 4'd0, 5'd0, 1'b0);
      push_px(0, 639, 3'd1, 4'd0, 5'd0, 1'b0);
      push_px(0, 640, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(0, 644, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(0, 655, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(0, 656, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(0, 751, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(0, 752, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(0, 789, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(0, 790, 3'd0, 4'd1, 5'd0, 1'b0);
      push_px(0, 797, 3'd0, 4'd1, 5'd0, 1'b0);
      push_px(0, 798, 3'd2, 4'd0, 5'd0, 1'b0);
      push_px(0, 799, 3'd2, 4'd0, 5'd0, 1'b0);
      push_px(1, 0,   3'd1, 4'd0, 5'd0, 1'b0);
      // Line 1: packet_valid rises at cx=645, too late for this line.
      push_px(1, 644, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(1, 652, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(1, 790, 3'd0, 4'd1, 5'd0, 1'b0);
      push_px(1, 799, 3'd2, 4'd0, 5'd0, 1'b0);
      // Line 2: valid held, two packets.
      push_px(2, 643, 3'd0, 4'd0,     5'd0,  1'b0);
      push_px(2, 644, 3'd0, 4'b0101,  5'd0,  1'b0);
      push_px(2, 651, 3'd0, 4'b0101,  5'd0,  1'b0);
      push_px(2, 652, 3'd4, 4'd0,     5'd0,  1'b0);
      push_px(2, 653, 3'd4, 4'd0,     5'd0,  1'b0);
      push_px(2, 654, 3'd3, 4'd0,     5'd0,  1'b0);
      push_px(2, 685, 3'd3, 4'd0,     5'd31, 1'b1);
      push_px(2, 686, 3'd3, 4'd0,     5'd0,  1'b0);
      push_px(2, 717, 3'd3, 4'd0,     5'd31, 1'b1);
      push_px(2, 718, 3'd4, 4'd0,     5'd0,  1'b0);
      push_px(2, 719, 3'd4, 4'd0,     5'd0,  1'b0);
      push_px(2, 720, 3'd0, 4'd0,     5'd0,  1'b0);
      // Line 3: valid dropped with the first ack, single packet.
      push_px(3, 685, 3'd3, 4'd0,     5'd31, 1'b1);
      push_px(3, 686, 3'd4, 4'd0,     5'd0,  1'b0);
      push_px(3, 687, 3'd4, 4'd0,     5'd0,  1'b0);
      push_px(3, 688, 3'd0, 4'd0,     5'd0,  1'b0);
      // Line 4: island interrupted by reset at packet_bit 10.
      push_px(4, 654, 3'd3, 4'd0,     5'd0,  1'b0);
      push_px(4, 664, 3'd3, 4'd0,     5'd10, 1'b0);
      push_ack(2, 685);
      push_ack(2, 717);
      push_ack(3, 685);

      @(negedge clk_pixel);
      reset_n = 1'b1;

      wait_pos(1, 645, 5000);
      packet_valid = 1'b1;
      wait_pos(3, 685, 5000);
      packet_valid = 1'b0;
      wait_pos(4, 100, 5000);
      packet_valid = 1'b1;
      wait_pos(4, 664, 5000);
      #2;
      reset_n = 1'b0;
      packet_valid = 1'b0;
      #1;
      check_vec("async_reset", 64'({cx, cy, mode, ctl, sync, packet_bit, packet_ack}), 64'd0);

      push_px(0, 0,   3'd1, 4'd0, 5'd0, 1'b0);
      push_px(0, 1,   3'd1, 4'd0, 5'd0, 1'b0);
      push_px(0, 643, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(0, 644, 3'd0, 4'd0, 5'd0, 1'b0);
      push_px(0, 654, 3'd0, 4'd0, 5'd0, 1'b0);

      repeat (2) @(negedge clk_pixel);
      reset_n = 1'b1;
      wait_pos(0, 700, 2000);
      repeat (2) @(posedge clk_pixel);
      #1;
      check_vec("pixel_queue_drained", 64'(px_q.size()), 64'd0);
      check_vec("ack_queue_drained", 64'(ack_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hdmi_period_scheduler.md
HDMI_PERIOD_SCHEDULER -- requirements
Module: hdmi_period_scheduler

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, front porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width.
REQ-004 SHALL have parameter H_BACK, default 48, back porch; H_TOTAL = sum of the four H parameters.
REQ-005 SHALL have parameters V_ACTIVE, V_FRONT, V_SYNC, V_BACK, defaults 480, 10, 2, 33; V_TOTAL = their sum.
REQ-006 SHALL have parameter ISLAND_START, default 4, data-island start offset after H_ACTIVE.
REQ-007 SHALL have parameter MAX_PACKETS, default 2, packets per island, range 1..18.
REQ-008 SHALL have port clk_pixel, input, 1 bit, the only clock.
REQ-009 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port packet_valid, input, 1 bit, source has a 32-cycle packet ready.
REQ-011 SHALL have port packet_ack, output, 1 bit, one-cycle pulse on the last cycle of each packet.
REQ-012 SHALL have port packet_bit, output, 5 bits, cycle index 0..31 within the current packet.
REQ-013 SHALL have port mode, output, 3 bits: 0 control, 1 video, 2 video guard, 3 island, 4 island guard.
REQ-014 SHALL have port ctl, output, 4 bits, CTL3..CTL0 for the channel-1/2 control codes.
REQ-015 SHALL have port sync, output, 2 bits, {vsync, hsync}, active high.
REQ-016 SHALL have ports cx and cy, outputs, 16 bits each, position aligned with mode.

Function
REQ-017 SHALL register all outputs; cx, cy, mode, ctl, sync, packet_bit and packet_ack in a given cycle SHALL describe the same pixel.
REQ-018 SHALL increment cx every cycle, wrap H_TOTAL-1 -> 0 and increment cy on the wrap, and wrap cy V_TOTAL-1 -> 0.
REQ-019 SHALL drive hsync=1 iff H_ACTIVE+H_FRONT <= cx < H_ACTIVE+H_FRONT+H_SYNC, and vsync=1 iff V_ACTIVE+V_FRONT <= cy < V_ACTIVE+V_FRONT+V_SYNC.
REQ-020 SHALL output mode=1 iff cx<H_ACTIVE and cy<V_ACTIVE.
REQ-021 SHALL, when the next line is active, output ctl=4'b0001 with mode=0 for cx H_TOTAL-10..H_TOTAL-3, then mode=2 for cx H_TOTAL-2..H_TOTAL-1 (video preamble and guard).
REQ-022 SHALL use island FSM states IDLE, DI_PRE, DI_LEAD, DI_PKT, DI_TRAIL.
REQ-023 SHALL leave IDLE only at cx==H_ACTIVE+ISLAND_START with packet_valid=1, on any line including vertical blanking; otherwise no island on that line.
REQ-024 SHALL in DI_PRE hold mode=0, ctl=4'b0101 for 8 cycles, then DI_LEAD mode=4 for 2 cycles.
REQ-025 SHALL in DI_PKT output mode=3, packet_bit counting 0..31, and packet_ack=1 at packet_bit==31.
REQ-026 SHALL at packet_bit==31 start another packet if packet_valid=1 and fewer than MAX_PACKETS packets are sent; otherwise go to DI_TRAIL.
REQ-027 SHALL in DI_TRAIL output mode=4 for 2 cycles, then IDLE with mode=0, ctl=0.
REQ-028 SHALL ignore packet_valid outside IDLE-start and packet-boundary cycles; the source SHALL hold packet_valid until packet_ack.
REQ-029 SHALL keep packet_bit=0 and packet_ack=0 outside DI_PKT.
REQ-030 SHALL fail elaboration unless H_ACTIVE+ISLAND_START+12+32*MAX_PACKETS <= H_TOTAL-10.
REQ-031 SHALL output ctl=0 in every cycle not covered by REQ-021 or REQ-024.

Reset
REQ-032 SHALL, while reset_n=0, immediately force cx=0, cy=0, FSM=IDLE, mode=0, ctl=0, sync=0, packet_bit=0, packet_ack=0.
REQ-033 SHALL abort any island on reset with no trailing guard, and resume at cx=0, cy=0 in the first cycle after reset_n rises.

Verification
REQ-034 SHALL check one frame with packet_valid=0: 800x525 cycles, mode=1 exactly 640x480 cycles, hsync at cx 656..751, vsync at cy 490..491.
REQ-035 SHALL check line cy=0 with the next line active: cx 790..797 gives ctl=0001 and mode=0, cx 798..799 gives mode=2, cx 0 of the next line gives mode=1.
REQ-036 SHALL check packet_valid=1 held: cx 644..651 gives ctl=0101, 652..653 mode=4, 654..717 mode=3 with packet_ack at cx 685 and 717, 718..719 mode=4, cx 720 mode=0.
REQ-037 SHALL check packet_valid dropped after the first ack: exactly one packet is sent, and DI_TRAIL occupies cx 686..687.
REQ-038 SHALL check reset_n pulled low at packet_bit=10: outputs go to reset values asynchronously; after release, cx=0 and mode=1.
REQ-039 SHALL check packet_valid rising at cx=645: no island starts on that line, and an island starts on the next line at cx=644.
